ace_instbuf: RTL and testbench

Decode-stage-0 instruction buffer. It receives up to 8 fetched instructions per cycle from the fetch f1→d0 pipeline registers and returns backpressure (instbuf_full) to fetch. It stores the instructions in a circular FIFO and delivers up to DEQ_W instructions per cycle, in program order, to the decoder. Pipeline flush from retire empties it.

---
 rtl/ace_instbuf_pkg.sv | 12 +
 rtl/ace_instbuf_if.sv | 43 ++++
 rtl/ace_instbuf_compact.sv | 35 +++
 rtl/ace_instbuf.sv | 121 ++++++++++++
 tb/tb_ace_instbuf.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ace_instbuf_pkg.sv
// ace_instbuf shared constants: fetch group width, instruction width
// and the free-space margin that drives backpressure to fetch.
package ace_instbuf_pkg;

  localparam int FETCH_W        = 8;
  localparam int INST_W         = 32;
  localparam int IB_FULL_MARGIN = 2 * FETCH_W;
  localparam int ENQ_NW         = $clog2(FETCH_W + 1);

  typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/ace_instbuf_if.sv
// Fetch/decode side bundle of the instruction buffer.
// slave: buffer side (inst in, deq out); master: fetch/decode/retire side.
interface ace_instbuf_if
  import ace_instbuf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DEQ_W = 4
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [FETCH_W-1:0]        inst_vld_i;
  logic [FETCH_W*INST_W-1:0] inst_i;
  logic                      flush_i;
  logic                      dec_stall_i;
  logic                      instbuf_full_o;
  logic [DEQ_W-1:0]          deq_vld_o;
  logic [DEQ_W*INST_W-1:0]   deq_inst_o;
  logic [CNTW-1:0]           count_o;

  modport master (
    output inst_vld_i,
    output inst_i,
    output flush_i,
    output dec_stall_i,
    input  instbuf_full_o,
    input  deq_vld_o,
    input  deq_inst_o,
    input  count_o
  );

  modport slave (
    input  inst_vld_i,
    input  inst_i,
    input  flush_i,
    input  dec_stall_i,
    output instbuf_full_o,
    output deq_vld_o,
    output deq_inst_o,
    output count_o
  );

endinterface

// File: rtl/ace_instbuf_compact.sv
// Packs the valid slots of a fetch group into lanes 0..enq_n-1.
// Ports: vld_i/inst_i group in; enq_n_o, pk_vld_o, pk_inst_o packed out.
module ace_instbuf_compact
  import ace_instbuf_pkg::*;
(
  input  logic [FETCH_W-1:0]        vld_i,
  input  logic [FETCH_W*INST_W-1:0] inst_i,
  output logic [ENQ_NW-1:0]         enq_n_o,
  output logic [FETCH_W-1:0]        pk_vld_o,
  output logic [FETCH_W*INST_W-1:0] pk_inst_o
);

  logic [ENQ_NW-1:0] pfx;

  always_comb begin
    pfx       = '0;
    pk_inst_o = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (vld_i[k]) begin
        pk_inst_o[pfx*INST_W +: INST_W] =
          inst_i[k*INST_W +: INST_W];
        pfx = pfx + ENQ_NW'(1);
      end
    end
  end

  assign enq_n_o = pfx;

  always_comb begin
    pk_vld_o = '0;
    for (int o = 0; o < FETCH_W; o++)
      pk_vld_o[o] = ENQ_NW'(o) < pfx;
  end

endmodule

// File: rtl/ace_instbuf.sv
// Decode-stage-0 instruction buffer: circular FIFO, 8-wide compacting
// enqueue, DEQ_W-wide in-order dequeue, registered full, retire flush.
module ace_instbuf
  import ace_instbuf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DEQ_W = 4
) (
  input logic          clock,
  input logic          reset_n,
  ace_instbuf_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = PW + 1;

  inst_t mem [DEPTH];

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             count;
  logic [PW-1:0]             deq_n_avail;
  logic [PW-1:0]             deq_n;
  logic [CW-1:0]             count_next;
  logic [CW-1:0]             occ_chk;
  logic                      fill_q;
  logic                      flush_q;
  logic                      full_q;
  logic                      full_d;
  logic                      enq_en;
  logic [FETCH_W-1:0]        enq_vld;
  logic [ENQ_NW-1:0]         enq_n;
  logic [FETCH_W-1:0]        pk_vld;
  logic [FETCH_W*INST_W-1:0] pk_inst;
  logic [AW-1:0]             wr_addr [FETCH_W];
  logic [AW-1:0]             rd_addr [DEQ_W];

  assign count = wr_ptr - rd_ptr;

  // fill_q says fetch really loaded a new group at the last edge;
  // flush_q covers fetch's one-cycle-late wrong-path invalidate.
  assign enq_en = fill_q & ~bus.flush_i & ~flush_q
                & (|bus.inst_vld_i);
  assign enq_vld = bus.inst_vld_i & {FETCH_W{enq_en}};

  ace_instbuf_compact u_compact (
    .vld_i     (enq_vld),
    .inst_i    (bus.inst_i),
    .enq_n_o   (enq_n),
    .pk_vld_o  (pk_vld),
    .pk_inst_o (pk_inst)
  );

  assign deq_n_avail = (count < PW'(DEQ_W)) ? count : PW'(DEQ_W);
  assign deq_n = (~bus.dec_stall_i & ~bus.flush_i)
               ? deq_n_avail : '0;

  assign count_next = CW'(count) + CW'(enq_n) - CW'(deq_n);
  // Free space below two fetch groups: one already latched by fetch
  // plus the one being latched now still fit.
  assign full_d = count_next > CW'(DEPTH - IB_FULL_MARGIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill_q  <= 1'b1;
      flush_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      fill_q  <= ~full_q;
      flush_q <= bus.flush_i;
      if (bus.flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        full_q <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + PW'(enq_n);
        rd_ptr <= rd_ptr + deq_n;
        full_q <= full_d;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FETCH_W; i++)
      wr_addr[i] = wr_ptr[AW-1:0] + AW'(i);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < FETCH_W; i++)
      if (pk_vld[i])
        mem[wr_addr[i]] <= pk_inst[i*INST_W +: INST_W];
  end

  always_comb begin
    for (int j = 0; j < DEQ_W; j++)
      rd_addr[j] = rd_ptr[AW-1:0] + AW'(j);
  end

  always_comb begin
    bus.deq_vld_o  = '0;
    bus.deq_inst_o = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      bus.deq_vld_o[j] = PW'(j) < deq_n_avail;
      bus.deq_inst_o[j*INST_W +: INST_W] = mem[rd_addr[j]];
    end
  end

  assign bus.instbuf_full_o = full_q;
  assign bus.count_o        = count;

  assign occ_chk = CW'(count) + CW'(enq_n);

  ovf_a: assert property (
    @(posedge clock) disable iff (!reset_n)
    occ_chk <= CW'(DEPTH)
  );

endmodule

// File: tb/tb_ace_instbuf.sv
// Bench for ace_instbuf: queue model checked every cycle plus
// directed vectors with literal expectations.
module tb_ace_instbuf;

  localparam int DEPTH  = 32;
  localparam int DEQ_W  = 4;
  localparam int MARGIN = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic chk_en  = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq [$];
  logic        m_full = 1'b0;
  logic        m_fill = 1'b1;
  logic        m_flq  = 1'b0;

  ace_instbuf_if #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) ib ();

  ace_instbuf #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ib.slave)
  );

  initial forever #5 clock = ~clock;

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] grp(input logic [31:0] base);
    logic [255:0] g;
    for (int k = 0; k < 8; k++) g[k*32 +: 32] = base + 32'(k);
    return g;
  endfunction

  function automatic logic [31:0] ln(input int j);
    return ib.deq_inst_o[j*32 +: 32];
  endfunction

  task automatic step(input logic [7:0] v, input logic [31:0] base,
                      input logic fl, input logic st);
    ib.inst_vld_i  = v;
    ib.inst_i      = grp(base);
    ib.flush_i     = fl;
    ib.dec_stall_i = st;
    @(negedge clock);
  endtask

  // Reference: a program-order queue; acceptance depends on the
  // previous cycle's full and a two-cycle flush shadow.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_full = 1'b0;
      m_fill = 1'b1;
      m_flq  = 1'b0;
    end else begin
      logic acc;
      int   n;
      acc    = m_fill && !ib.flush_i && !m_flq;
      m_fill = !m_full;
      if (ib.flush_i) begin
        mq.delete();
        m_full = 1'b0;
      end else begin
        if (!ib.dec_stall_i) begin
          n = (mq.size() < DEQ_W) ? mq.size() : DEQ_W;
          repeat (n) void'(mq.pop_front());
        end
        if (acc)
          for (int k = 0; k < 8; k++)
            if (ib.inst_vld_i[k]) mq.push_back(ib.inst_i[k*32 +: 32]);
        m_full = (DEPTH - mq.size()) < MARGIN;
      end
      m_flq = ib.flush_i;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      int n;
      n = (mq.size() < DEQ_W) ? mq.size() : DEQ_W;
      cmp("m_count", 64'(ib.count_o), 64'(mq.size()));
      cmp("m_full", 64'(ib.instbuf_full_o), 64'(m_full));
      cmp("m_vld", 64'(ib.deq_vld_o), 64'((1 << n) - 1));
      for (int j = 0; j < n; j++)
        cmp("m_lane", 64'(ln(j)), 64'(mq[j]));
    end
  end

  initial begin
    ib.inst_vld_i  = '0;
    ib.inst_i      = '0;
    ib.flush_i     = 1'b0;
    ib.dec_stall_i = 1'b0;
    @(negedge clock);
    cmp("rst_count", 64'(ib.count_o), 64'd0);
    cmp("rst_full", 64'(ib.instbuf_full_o), 64'd0);
    cmp("rst_vld", 64'(ib.deq_vld_o), 64'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    step(8'b1010_0100, 32'hA0, 1'b0, 1'b0);
    cmp("sp_count", 64'(ib.count_o), 64'd3);
    cmp("sp_vld", 64'(ib.deq_vld_o), 64'b0111);
    cmp("sp_l0", 64'(ln(0)), 64'hA2);
    cmp("sp_l1", 64'(ln(1)), 64'hA5);
    cmp("sp_l2", 64'(ln(2)), 64'hA7);
    step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("sp_drain", 64'(ib.count_o), 64'd0);
    cmp("sp_vld0", 64'(ib.deq_vld_o), 64'd0);

    step(8'hFF, 32'h100, 1'b0, 1'b1);
    cmp("g_count", 64'(ib.count_o), 64'd8);
    cmp("g_vld", 64'(ib.deq_vld_o), 64'hF);
    cmp("g_full", 64'(ib.instbuf_full_o), 64'd0);
    for (int j = 0; j < 4; j++)
      cmp("g_lane", 64'(ln(j)), 64'(32'h100 + j));

    step(8'hFF, 32'h200, 1'b0, 1'b1);
    cmp("f_c16", 64'(ib.count_o), 64'd16);
    cmp("f_full16", 64'(ib.instbuf_full_o), 64'd0);
    step(8'hFF, 32'h208, 1'b0, 1'b1);
    cmp("f_c24", 64'(ib.count_o), 64'd24);
    cmp("f_full24", 64'(ib.instbuf_full_o), 64'd1);
    step(8'hFF, 32'h210, 1'b0, 1'b1);
    cmp("f_c32", 64'(ib.count_o), 64'd32);
    step(8'hFF, 32'h218, 1'b0, 1'b1);
    cmp("f_stale1", 64'(ib.count_o), 64'd32);
    step(8'hFF, 32'h220, 1'b0, 1'b1);
    cmp("f_stale2", 64'(ib.count_o), 64'd32);
    cmp("f_full32", 64'(ib.instbuf_full_o), 64'd1);

    step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("d_c28", 64'(ib.count_o), 64'd28);
    cmp("d_l0", 64'(ln(0)), 64'h104);
    step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("d_l3", 64'(ln(3)), 64'h203);
    step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("d_c20", 64'(ib.count_o), 64'd20);

    step(8'hFF, 32'h300, 1'b1, 1'b0);
    cmp("fl_count", 64'(ib.count_o), 64'd0);
    cmp("fl_full", 64'(ib.instbuf_full_o), 64'd0);
    step(8'hFF, 32'h310, 1'b0, 1'b1);
    cmp("fl_drop1", 64'(ib.count_o), 64'd0);
    step(8'hFF, 32'h320, 1'b0, 1'b1);
    cmp("fl_acc", 64'(ib.count_o), 64'd8);
    cmp("fl_l0", 64'(ln(0)), 64'h320);

    step(8'hFF, 32'h330, 1'b0, 1'b1);
    step(8'hFF, 32'h338, 1'b0, 1'b1);
    step(8'h0F, 32'h340, 1'b0, 1'b1);
    cmp("w_c28", 64'(ib.count_o), 64'd28);
    repeat (7) step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("w_empty", 64'(ib.count_o), 64'd0);
    step(8'hFF, 32'h400, 1'b0, 1'b1);
    cmp("w_c8", 64'(ib.count_o), 64'd8);
    for (int j = 0; j < 4; j++)
      cmp("w_lo", 64'(ln(j)), 64'(32'h400 + j));
    step(8'h00, 32'h0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++)
      cmp("w_hi", 64'(ln(j)), 64'(32'h404 + j));
    step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("w_done", 64'(ib.count_o), 64'd0);

    step(8'h3F, 32'h500, 1'b0, 1'b1);
    cmp("s_c6", 64'(ib.count_o), 64'd6);
    step(8'h1F, 32'h600, 1'b0, 1'b0);
    cmp("s_c7", 64'(ib.count_o), 64'd7);
    cmp("s_vld", 64'(ib.deq_vld_o), 64'hF);
    cmp("s_l0", 64'(ln(0)), 64'h504);
    cmp("s_l1", 64'(ln(1)), 64'h505);
    cmp("s_l2", 64'(ln(2)), 64'h600);
    cmp("s_l3", 64'(ln(3)), 64'h601);
    step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("s_c3", 64'(ib.count_o), 64'd3);
    cmp("s_vld3", 64'(ib.deq_vld_o), 64'b0111);
    step(8'h00, 32'h0, 1'b0, 1'b0);
    cmp("s_end", 64'(ib.count_o), 64'd0);

    step(8'h00, 32'h0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
